// File: rtl/p_neg_arb.sv
// Round-robin arbiter sharing one sign-negation unit between REQ requesters,
// with a single registered output slot and a saturating overflow counter.

package p_neg_pkg;
  typedef enum logic [1:0] {BOOL = 2'd0, INT = 2'd1, FXP = 2'd2, FP = 2'd3} dtype_e;

  typedef struct packed {
    dtype_e      dtype;
    logic [15:0] prec;
  } dconf_t;
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF p_neg_pkg::dconf_t'{dtype: p_neg_pkg::INT, prec: 16'd8}
`endif

module p_neg_arb #(
  parameter p_neg_pkg::dconf_t CONF = `DEF_DCONF,
  parameter int REQ  = 4,
  parameter int CNTW = 16,
  localparam int PREC = int'(CONF.prec),
  localparam int IDW  = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [REQ-1:0]        req_valid,
  input  logic [REQ*PREC-1:0]   req_data,
  output logic [REQ-1:0]        req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PREC-1:0]       out_data,
  output logic                  out_ovf,
  output logic [IDW-1:0]        out_id,
  output logic [CNTW-1:0]       ovf_cnt,
  input  logic                  ovf_clr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [PREC-1:0] ONE  = 1;
  localparam logic [PREC-1:0] SIGN = ONE << (PREC - 1);
  localparam logic [IDW-1:0]  LAST = IDW'(REQ - 1);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic            can_accept;
  logic [REQ-1:0]  grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            take;
  logic [PREC-1:0] op;
  logic [PREC-1:0] neg_data;
  logic            neg_ovf;
  logic [IDW-1:0]  nxt_ptr;

  // The slot can take a new operand when empty, or when its current result leaves this cycle.
  assign can_accept = (state == EMPTY) | out_ready;
  assign out_valid  = (state == FULL);

  always_comb begin : arb
    int idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = (int'(rr_ptr) + k) % REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = IDW'(idx);
      end
    end
  end

  assign req_ready = (reset_ && can_accept) ? grant : '0;
  assign take      = |req_ready;
  assign nxt_ptr   = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    op = req_data[gnt_idx*PREC +: PREC];
  end

  // The most-negative integer has no positive counterpart, so it clamps to the largest positive value.
  always_comb begin
    neg_data = op;
    neg_ovf  = 1'b0;
    case (CONF.dtype)
      p_neg_pkg::BOOL: begin
        neg_data    = '0;
        neg_data[0] = ~op[0];
      end
      p_neg_pkg::FP: begin
        neg_data = op ^ SIGN;
      end
      default: begin
        if (op == SIGN) begin
          neg_data = ~SIGN;
          neg_ovf  = 1'b1;
        end else begin
          neg_data = ~op + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= EMPTY;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (take) begin
      state    <= FULL;
      out_data <= neg_data;
      out_ovf  <= neg_ovf;
      out_id   <= gnt_idx;
      rr_ptr   <= nxt_ptr;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_cnt != {CNTW{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: doc/p_neg_arb.md
Name: p_neg_arb

Overview:
- Round-robin scheduler sharing one sign-negation datapath between REQ requesters.
- Each requester offers an operand over a valid/ready handshake. The block grants one requester per cycle and negates the operand according to CONF.dtype.
- The result, its overflow flag and the requester ID go into a single registered output slot with a valid/ready handshake.
- A saturating overflow event counter supports debug and statistics.
- Sits between the perceptron weight/activation update logic and the accumulators, wherever several lanes need negated operands but only one negation unit is budgeted.

Parameters:
- CONF, `DEF_DCONF (dconf_t): data configuration. CONF.prec is the operand width PREC; CONF.dtype is BOOL, INT, FXP or FP.
- REQ, 4: number of requesters, >= 2.
- CNTW, 16: overflow counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_  in  1  asynchronous active-low reset.
- req_valid  in  REQ  per-requester operand valid.
- req_data  in  REQ*PREC  packed operands; requester i uses bits [i*PREC +: PREC].
- req_ready  out  REQ  one-hot grant, or all zero.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  PREC  negated operand.
- out_ovf  out  1  overflow flag of out_data.
- out_id  out  max(1,$clog2(REQ))  index of the requester that produced out_data.
- ovf_cnt  out  CNTW  saturating count of accepted results with overflow.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (reset_=0, asynchronous): out_valid=0, out_data=0, out_ovf=0, out_id=0, rr_ptr=0, ovf_cnt=0. req_ready is forced to 0 while reset_ is low.
- Output slot state machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot acceptance:
  - can_accept = (state==EMPTY) | out_ready. This gives a full-throughput single-stage pipe.
  - out_ready and out_valid are combined only through registered state; no combinational path from out_ready to out_data.
- Arbitration:
  - Active only when can_accept=1.
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo REQ.
  - req_ready[i]=1 only for the granted i. req_ready is a combinational function of req_valid, rr_ptr and state/out_ready.
  - Requesters must not make req_valid depend on req_ready.
  - When can_accept=0 or no request is valid, req_ready is all zero.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. At that edge:
  - out_data, out_ovf and out_id load the negation of req_data[i], its overflow flag and i.
  - State becomes FULL.
  - rr_ptr becomes (i+1) mod REQ.
- Pointer hold: rr_ptr is unchanged on cycles without a grant.
- Drain: on out_valid & out_ready with no new grant, state becomes EMPTY and out_data/out_ovf/out_id hold their last values.
- Simultaneous drain and grant: the slot reloads and stays FULL, with no bubble.
- Stall: while FULL & !out_ready, out_data/out_ovf/out_id are stable and req_ready is all zero.
- Latency: 1 cycle from accepted request to out_valid.
- Negation per CONF.dtype:
  - BOOL: out = {0..0, ~in[0]}; ovf=0.
  - INT/FXP: two's complement. Most-negative input (MSB=1, rest 0) saturates to {0,1..1} with ovf=1; otherwise ~in+1 truncated to PREC bits, ovf=0.
  - FP: sign bit inverted, remaining bits unchanged; ovf=0.
- ovf_cnt:
  - Increments by 1 on each downstream transfer (out_valid & out_ready) with out_ovf=1.
  - Saturates at 2^CNTW-1.
  - If ovf_clr is asserted in the same cycle as an increment, ovf_clr wins and the counter becomes 0.
- Reset mid-operation: all pending results and the pointer are discarded.

Test Plan:
- REQ=4, INT, PREC=8; reset then idle -> out_valid=0, req_ready=0000, ovf_cnt=0. Assert req_valid[2] with data 0x05 while out_ready=1 -> req_ready=0100; next cycle out_data=0xFB, out_ovf=0, out_id=2.
- All four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... with one result per cycle and out_id sequence 0,1,2,3,0.
- Requester 1 sends 0x80 -> out_data=0x7F, out_ovf=1. After downstream accept, ovf_cnt=1. Sending 0x00 -> out_data=0x00, ovf=0.
- out_ready=0 for 3 cycles while FULL -> out_data stable, req_ready=0000. Then out_ready=1 with req_valid[3]=1 -> same-cycle drain and reload, out_valid stays 1.
- FP PREC=16 input 0x3C00 -> 0xBC00. BOOL input 1 -> 0. In both cases ovf=0.
- CNTW=2: four accepted overflow results -> ovf_cnt saturates at 3. ovf_clr together with an overflow accept -> ovf_cnt=0. reset_ low mid-transfer -> out_valid=0 immediately.
